// File: rtl/gpio_write_buffer.sv
// gpio_write_buffer: queues MEM-stage GPIO stores in a FIFO and delivers each
// one to its output channel over a per-channel valid/ready handshake. Keeps a
// readback shadow of the last value delivered on each channel, and sticky
// flags for stores that were dropped or that hit an unmapped address.
module gpio_write_buffer #(
   parameter int unsigned          DATA_W    = 8,
   parameter int unsigned          ADDR_W    = 32,
   parameter int unsigned          DEPTH     = 8,
   parameter int unsigned          CHANNELS  = 4,
   parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(32'h0000_1000),
   localparam int unsigned         CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned         LVL_W     = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         stall,
   output logic [CHANNELS*DATA_W-1:0]   ch_data,
   output logic [CHANNELS-1:0]          ch_valid,
   input  logic [CHANNELS-1:0]          ch_ready,
   input  logic [CH_W-1:0]              rd_ch,
   output logic [DATA_W-1:0]            rd_data,
   output logic [LVL_W-1:0]             level,
   output logic                         err_ovf,
   output logic                         err_addr,
   input  logic                         clr_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   // FIFO storage: the head is read combinationally at rd_ptr_q
   logic [DATA_W-1:0]          mem_data_q [DEPTH];
   logic [CH_W-1:0]            mem_ch_q   [DEPTH];

   logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]           level_q, level_d;

   // Output stage: one-hot valid plus lane-placed data, with the channel index
   logic [CH_W-1:0]            out_ch_q, out_ch_d;
   logic [CHANNELS-1:0]        ch_valid_q, ch_valid_d;
   logic [CHANNELS*DATA_W-1:0] ch_data_q, ch_data_d;

   logic [DATA_W-1:0]          shadow_q [CHANNELS];
   logic [DATA_W-1:0]          shadow_d [CHANNELS];
   logic                       err_ovf_q, err_ovf_d;
   logic                       err_addr_q, err_addr_d;

   logic [ADDR_W-1:0]          offset;
   logic                       in_range;
   logic [CH_W-1:0]            wr_ch;
   logic                       full;
   logic                       empty;
   logic                       handshake;
   logic                       push;
   logic                       pop;
   logic [DATA_W-1:0]          out_data;

   // Address decode, FIFO status and handshake qualification
   always_comb begin
      offset    = wr_addr - BASE_ADDR;
      in_range  = (offset < ADDR_W'(CHANNELS));
      wr_ch     = offset[CH_W-1:0];
      full      = (level_q == LVL_W'(DEPTH));
      empty     = (level_q == '0);
      handshake = |(ch_valid_q & ch_ready);
      push      = wr_en && in_range && !full;
      pop       = (!(|ch_valid_q) || handshake) && !empty;
      out_data  = ch_data_q[32'(out_ch_q) * DATA_W +: DATA_W];
   end

   // Next-state logic for pointers, level, output stage, shadows and flags
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      out_ch_d   = out_ch_q;
      ch_valid_d = ch_valid_q;
      ch_data_d  = ch_data_q;
      shadow_d   = shadow_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      if (handshake) begin
         shadow_d[out_ch_q] = out_data;
      end

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         out_ch_d   = mem_ch_q[rd_ptr_q];
         ch_valid_d = '0;
         ch_valid_d[mem_ch_q[rd_ptr_q]] = 1'b1;
         ch_data_d  = '0;
         ch_data_d[32'(mem_ch_q[rd_ptr_q]) * DATA_W +: DATA_W] = mem_data_q[rd_ptr_q];
      end else if (handshake) begin
         ch_valid_d = '0;
         ch_data_d  = '0;
      end

      // A set event outranks a simultaneous clear
      err_ovf_d  = (wr_en && in_range && full) || (err_ovf_q && !clr_err);
      err_addr_d = (wr_en && !in_range) || (err_addr_q && !clr_err);
   end

   // State registers; reset discards queued and in-flight data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         out_ch_q   <= '0;
         ch_valid_q <= '0;
         ch_data_q  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            shadow_q[k] <= '0;
         end
         err_ovf_q  <= 1'b0;
         err_addr_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         out_ch_q   <= out_ch_d;
         ch_valid_q <= ch_valid_d;
         ch_data_q  <= ch_data_d;
         shadow_q   <= shadow_d;
         err_ovf_q  <= err_ovf_d;
         err_addr_q <= err_addr_d;
      end
   end

   // FIFO payload write; contents are meaningless until pushed, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= wr_data;
         mem_ch_q[wr_ptr_q]   <= wr_ch;
      end
   end

   assign stall    = full;
   assign level    = level_q;
   assign ch_valid = ch_valid_q;
   assign ch_data  = ch_data_q;
   assign rd_data  = shadow_q[rd_ch];
   assign err_ovf  = err_ovf_q;
   assign err_addr = err_addr_q;

endmodule

// File: tb/tb_gpio_write_buffer.sv
// tb_gpio_write_buffer: directed stimulus with a delivery scoreboard for
// gpio_write_buffer at default parameters (8-bit data, 8 deep, 4 channels).
module tb_gpio_write_buffer;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [7:0]  wr_data;
   logic        stall;
   logic [31:0] ch_data;
   logic [3:0]  ch_valid;
   logic [3:0]  ch_ready;
   logic [1:0]  rd_ch;
   logic [7:0]  rd_data;
   logic [3:0]  level;
   logic        err_ovf;
   logic        err_addr;
   logic        clr_err;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_deliv = 0;
   logic [15:0] sb [$];

   gpio_write_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .stall    (stall),
      .ch_data  (ch_data),
      .ch_valid (ch_valid),
      .ch_ready (ch_ready),
      .rd_ch    (rd_ch),
      .rd_data  (rd_data),
      .level    (level),
      .err_ovf  (err_ovf),
      .err_addr (err_addr),
      .clr_err  (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_drained(input int budget);
      logic done;
      done = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sb.size() == 0 && level == 4'd0 && ch_valid == 4'd0) begin
            done = 1'b1;
            break;
         end
         step(1);
      end
      check("drain_timeout", 64'(done), 64'd1);
   endtask

   // Scoreboard: a handshake is committed at the next rising edge whenever
   // valid and ready overlap at the falling edge
   always @(negedge clk) begin
      if (rst === 1'b1 && (ch_valid & ch_ready) != 4'd0) begin
         logic [15:0] got;
         logic [15:0] exp;
         got = '0;
         for (int k = 0; k < 4; k++) begin
            if (ch_valid[k] && ch_ready[k]) begin
               got = {8'(k), ch_data[k*8 +: 8]};
            end
         end
         exp = (sb.size() > 0) ? sb.pop_front() : 16'hFFFF;
         n_deliv++;
         check("delivery", 64'(got), 64'(exp));
      end
   end

   initial begin
      rst      = 1'b0;
      wr_en    = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      ch_ready = '0;
      rd_ch    = '0;
      clr_err  = 1'b0;

      // Reset state
      #12;
      check("rst_level",    64'(level),    64'd0);
      check("rst_stall",    64'(stall),    64'd0);
      check("rst_ch_valid", 64'(ch_valid), 64'd0);
      check("rst_ch_data",  64'(ch_data),  64'd0);
      check("rst_rd_data",  64'(rd_data),  64'd0);
      check("rst_errs",     64'({err_ovf, err_addr}), 64'd0);
      #1 rst = 1'b1;
      step(1);

      // Single write to channel 2: two-edge latency, then shadow readback
      wr_en = 1'b1; wr_addr = BASE + 32'd2; wr_data = 8'hA5;
      sb.push_back({8'd2, 8'hA5});
      step(1);
      wr_en = 1'b0;
      check("t1_level_e0",    64'(level),    64'd1);
      check("t1_valid_e0",    64'(ch_valid), 64'd0);
      step(1);
      check("t1_valid_e1",    64'(ch_valid), 64'b0100);
      check("t1_data_e1",     64'(ch_data),  64'h00A5_0000);
      check("t1_level_e1",    64'(level),    64'd0);
      ch_ready = 4'b0100;
      step(1);
      check("t1_valid_e2",    64'(ch_valid), 64'd0);
      rd_ch = 2'd2;
      #1;
      check("t1_rd_data",     64'(rd_data),  64'hA5);
      ch_ready = 4'b0000;

      // Fill channel 0 with ready low, then overflow
      for (int i = 1; i <= 9; i++) begin
         wr_en = 1'b1; wr_addr = BASE; wr_data = 8'(i);
         sb.push_back({8'd0, 8'(i)});
         step(1);
      end
      check("t2_level_full",  64'(level),    64'd8);
      check("t2_stall",       64'(stall),    64'd1);
      wr_data = 8'd10;
      step(1);
      wr_en = 1'b0;
      check("t2_err_ovf",     64'(err_ovf),  64'd1);
      check("t2_err_addr",    64'(err_addr), 64'd0);
      check("t2_level_kept",  64'(level),    64'd8);
      check("t2_head",        64'({ch_valid, ch_data}), {28'd0, 4'b0001, 32'h0000_0001});
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("t2_ovf_clr",     64'(err_ovf),  64'd0);
      ch_ready = 4'b0001;
      step(9);
      check("t2_tput_level",  64'(level),    64'd0);
      check("t2_tput_valid",  64'(ch_valid), 64'd0);
      rd_ch = 2'd0;
      #1;
      check("t2_rd_data",     64'(rd_data),  64'h09);
      ch_ready = 4'b0000;

      // Out-of-range addresses and sticky clear priority
      wr_en = 1'b1; wr_addr = BASE + 32'd4; wr_data = 8'h77;
      step(1);
      wr_en = 1'b0;
      check("t3_err_hi",      64'(err_addr), 64'd1);
      check("t3_level_hi",    64'(level),    64'd0);
      check("t3_valid_hi",    64'(ch_valid), 64'd0);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("t3_clr",         64'(err_addr), 64'd0);
      wr_en = 1'b1; wr_addr = BASE - 32'd1;
      step(1);
      wr_en = 1'b0;
      check("t3_err_lo",      64'(err_addr), 64'd1);
      check("t3_level_lo",    64'(level),    64'd0);
      clr_err = 1'b1; wr_en = 1'b1; wr_addr = BASE + 32'd7;
      step(1);
      clr_err = 1'b0; wr_en = 1'b0;
      check("t3_set_wins",    64'(err_addr), 64'd1);
      check("t3_no_ovf",      64'(err_ovf),  64'd0);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      check("t3_clr2",        64'(err_addr), 64'd0);

      // Backpressure on channel 1 while channel 0 is ready
      ch_ready = 4'b0001;
      wr_en = 1'b1; wr_addr = BASE + 32'd1; wr_data = 8'h3C;
      sb.push_back({8'd1, 8'h3C});
      step(1);
      wr_addr = BASE; wr_data = 8'h11;
      sb.push_back({8'd0, 8'h11});
      step(1);
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", 64'(ch_valid), 64'b0010);
         check("t4_hold_data",  64'(ch_data),  64'h0000_3C00);
         check("t4_hold_level", 64'(level),    64'd1);
         step(1);
      end
      ch_ready = 4'b0011;
      step(1);
      ch_ready = 4'b0001;
      check("t4_next_valid",  64'(ch_valid), 64'b0001);
      check("t4_next_data",   64'(ch_data),  64'h0000_0011);
      step(1);
      check("t4_done_valid",  64'(ch_valid), 64'd0);
      ch_ready = 4'b0000;

      // Simultaneous push and pop while full: the push is still rejected
      for (int i = 0; i < 9; i++) begin
         wr_en = 1'b1; wr_addr = BASE + 32'd3; wr_data = 8'(8'h20 + i);
         sb.push_back({8'd3, 8'(8'h20 + i)});
         step(1);
      end
      wr_en = 1'b0;
      check("t5_level_full",  64'(level),    64'd8);
      check("t5_stall",       64'(stall),    64'd1);
      check("t5_valid",       64'(ch_valid), 64'b1000);
      ch_ready = 4'b1000;
      wr_en = 1'b1; wr_addr = BASE + 32'd3; wr_data = 8'hEE;
      step(1);
      wr_en = 1'b0;
      check("t5_level_dec",   64'(level),    64'd7);
      check("t5_err_ovf",     64'(err_ovf),  64'd1);
      check("t5_stall_off",   64'(stall),    64'd0);
      wait_drained(20);
      rd_ch = 2'd3;
      #1;
      check("t5_rd_data",     64'(rd_data),  64'h28);
      ch_ready = 4'b0000;
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;

      // Asynchronous reset between edges with data queued and in flight
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_addr = BASE + 32'd1; wr_data = 8'(8'h40 + i);
         step(1);
      end
      wr_en = 1'b0;
      check("t6_level_pre",   64'(level),    64'd5);
      #1 rst = 1'b0;
      #1;
      check("t6_level",       64'(level),    64'd0);
      check("t6_stall",       64'(stall),    64'd0);
      check("t6_valid",       64'(ch_valid), 64'd0);
      check("t6_data",        64'(ch_data),  64'd0);
      check("t6_rd_data3",    64'(rd_data),  64'd0);
      rd_ch = 2'd0;
      #1;
      check("t6_rd_data0",    64'(rd_data),  64'd0);
      @(negedge clk);
      #1 rst = 1'b1;
      step(1);
      wr_en = 1'b1; wr_addr = BASE + 32'd3; wr_data = 8'h5A;
      sb.push_back({8'd3, 8'h5A});
      step(1);
      wr_en = 1'b0;
      check("t6_lat_e0",      64'(ch_valid), 64'd0);
      step(1);
      check("t6_lat_e1",      64'(ch_valid), 64'b1000);
      check("t6_lat_data",    64'(ch_data),  64'h5A00_0000);
      ch_ready = 4'b1000;
      step(1);
      ch_ready = 4'b0000;
      check("t6_done",        64'(ch_valid), 64'd0);
      rd_ch = 2'd3;
      #1;
      check("t6_rd_data",     64'(rd_data),  64'h5A);

      step(2);
      check("sb_empty",       64'(sb.size()), 64'd0);
      check("deliveries",     64'(n_deliv),   64'd22);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
